// File: rtl/series_ctrl_p_pkg.sv
// Shared types for the power-series controller and its datapath.
// State encoding, strobe bundle order, default sizes.
package series_pkg;

  localparam int MAX_TERMS_D = 8;
  localparam int TW_D        = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    INIT  = 3'd2,
    MUL_Q = 3'd3,
    MUL_R = 3'd4,
    ACC   = 3'd5,
    DONE  = 3'd6
  } state_e;

  // Strobe bundle, MSB first; datapath decodes the same order.
  typedef struct packed {
    logic in0;
    logic selx;
    logic ldq;
    logic lde;
    logic ldt;
    logic selq;
    logic selrom;
    logic selt;
    logic selm;
    logic sela;
    logic sub;
  } strobe_t;

  localparam int STB_W = $bits(strobe_t);

endpackage

// File: rtl/series_ctrl_p_if.sv
// Handshake and datapath strobe bundle of the series controller.
// master: top level / datapath side; slave: controller.
interface series_ctrl_p_if
  import series_pkg::*;
#(
  parameter int TW = TW_D
);

  logic          Start;
  logic [TW-1:0] nterms;
  logic          alt;
  logic          mul_done;

  logic          mul_go;
  logic          in0;
  logic          selx;
  logic          ldq;
  logic          lde;
  logic          ldt;
  logic          selq;
  logic          selrom;
  logic          selt;
  logic          selm;
  logic          sela;
  logic          sub;
  logic [TW-1:0] rom_addr;
  logic [TW-1:0] term_idx;
  logic          busy;
  logic          ready;
  logic          done;

  modport master (
    output Start, nterms, alt, mul_done,
    input  mul_go, in0, selx, ldq, lde,
    input  ldt, selq, selrom, selt, selm,
    input  sela, sub, rom_addr, term_idx,
    input  busy, ready, done
  );

  modport slave (
    input  Start, nterms, alt, mul_done,
    output mul_go, in0, selx, ldq, lde,
    output ldt, selq, selrom, selt, selm,
    output sela, sub, rom_addr, term_idx,
    output busy, ready, done
  );

endinterface

// File: rtl/series_ctrl_p_term_cnt.sv
// Term index counter with last-term compare.
// i_clr zeroes, i_inc steps; o_last when o_cnt == i_n-1.
module series_term_cnt
  import series_pkg::*;
#(
  parameter int TW = TW_D
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_inc,
  input  logic [TW-1:0] i_n,
  output logic [TW-1:0] o_cnt,
  output logic          o_last
);

  logic [TW-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_cnt <= '0;
    else if (i_clr)
      r_cnt <= '0;
    else if (i_inc)
      r_cnt <= r_cnt + TW'(1);
  end

  assign o_cnt  = r_cnt;
  assign o_last = (r_cnt == i_n - TW'(1));

endmodule

// File: rtl/series_ctrl_p.sv
// Controller for iterative power-series datapaths.
// Ports: Clk, Rst (async high), bus (slave modport).
module series_ctrl_p
  import series_pkg::*;
#(
  parameter int MAX_TERMS = MAX_TERMS_D,
  parameter int TW        = TW_D,
  parameter int MUL_WAIT  = 0
) (
  input  logic           Clk,
  input  logic           Rst,
  series_ctrl_p_if.slave bus
);

  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_ARM   = ARM;
  localparam logic [2:0] S_INIT  = INIT;
  localparam logic [2:0] S_MUL_Q = MUL_Q;
  localparam logic [2:0] S_MUL_R = MUL_R;
  localparam logic [2:0] S_ACC   = ACC;
  localparam logic [2:0] S_DONE  = DONE;

  localparam logic [TW-1:0] MAX_N = TW'(MAX_TERMS);

  logic [2:0]    r_state;
  logic [2:0]    w_nxt;
  logic [TW-1:0] r_nterms;
  logic          r_alt;
  logic          r_go;
  logic [TW-1:0] w_ntc;
  logic [TW-1:0] w_idx;
  logic          w_last;
  logic          w_adv;
  logic          w_clr;
  logic          w_inc;
  logic          w_nxt_mul;
  strobe_t       w_stb;

  assign w_ntc = (bus.nterms > MAX_N) ? MAX_N
                                      : bus.nterms;

  // Multiply stage completes this cycle.
  assign w_adv = (MUL_WAIT == 0) ? 1'b1 : bus.mul_done;

  assign w_clr = (r_state == S_INIT);
  assign w_inc = (r_state == S_ACC) && !w_last;

  series_term_cnt #(
    .TW (TW)
  ) u_cnt (
    .i_clk  (Clk),
    .i_rst  (Rst),
    .i_clr  (w_clr),
    .i_inc  (w_inc),
    .i_n    (r_nterms),
    .o_cnt  (w_idx),
    .o_last (w_last)
  );

  always_comb begin
    w_nxt = S_IDLE;
    case (r_state)
      S_IDLE:  w_nxt = bus.Start ? S_ARM : S_IDLE;
      S_ARM:   w_nxt = bus.Start ? S_ARM : S_INIT;
      S_INIT:  w_nxt = (r_nterms == '0) ? S_DONE
                                        : S_MUL_Q;
      S_MUL_Q: w_nxt = w_adv ? S_MUL_R : S_MUL_Q;
      S_MUL_R: w_nxt = w_adv ? S_ACC : S_MUL_R;
      S_ACC:   w_nxt = w_last ? S_DONE : S_MUL_Q;
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // Every MUL entry comes from a different state.
  assign w_nxt_mul = (w_nxt == S_MUL_Q)
                  || (w_nxt == S_MUL_R);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state  <= S_IDLE;
      r_nterms <= '0;
      r_alt    <= 1'b0;
      r_go     <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_go    <= w_nxt_mul && (w_nxt != r_state);
      if (r_state == S_IDLE && bus.Start) begin
        r_nterms <= w_ntc;
        r_alt    <= bus.alt;
      end
    end
  end

  always_comb begin
    w_stb = '0;
    case (r_state)
      S_INIT: begin
        w_stb.in0  = 1'b1;
        w_stb.selx = 1'b1;
        w_stb.ldq  = 1'b1;
        w_stb.lde  = 1'b1;
        w_stb.ldt  = 1'b1;
      end
      S_MUL_Q: begin
        w_stb.selq = 1'b1;
        w_stb.selt = 1'b1;
        w_stb.selm = 1'b1;
        w_stb.ldt  = w_adv;
      end
      S_MUL_R: begin
        w_stb.selrom = 1'b1;
        w_stb.selt   = 1'b1;
        w_stb.selm   = 1'b1;
        w_stb.ldt    = w_adv;
      end
      S_ACC: begin
        w_stb.lde  = 1'b1;
        w_stb.sela = 1'b1;
        w_stb.sub  = r_alt & w_idx[0];
      end
      default: w_stb = '0;
    endcase
  end

  assign bus.in0    = w_stb.in0;
  assign bus.selx   = w_stb.selx;
  assign bus.ldq    = w_stb.ldq;
  assign bus.lde    = w_stb.lde;
  assign bus.ldt    = w_stb.ldt;
  assign bus.selq   = w_stb.selq;
  assign bus.selrom = w_stb.selrom;
  assign bus.selt   = w_stb.selt;
  assign bus.selm   = w_stb.selm;
  assign bus.sela   = w_stb.sela;
  assign bus.sub    = w_stb.sub;

  assign bus.mul_go   = r_go;
  assign bus.rom_addr = w_idx;
  assign bus.term_idx = w_idx;
  assign bus.ready    = (r_state == S_IDLE);
  assign bus.done     = (r_state == S_DONE);
  assign bus.busy     = (r_state == S_ARM)
                     || (r_state == S_INIT)
                     || (r_state == S_MUL_Q)
                     || (r_state == S_MUL_R)
                     || (r_state == S_ACC)
                     || (r_state == S_DONE);

endmodule

// File: tb/tb_series_ctrl_p.sv
// Directed bench for series_ctrl_p.
// u0: MUL_WAIT=0, u1: MUL_WAIT=1, both MAX_TERMS=8.
module tb_series_ctrl_p;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  series_ctrl_p_if #(.TW(4)) if0 ();
  series_ctrl_p_if #(.TW(4)) if1 ();

  series_ctrl_p #(
    .MAX_TERMS (8),
    .TW        (4),
    .MUL_WAIT  (0)
  ) u0 (
    .Clk (clk),
    .Rst (rst),
    .bus (if0)
  );

  series_ctrl_p #(
    .MAX_TERMS (8),
    .TW        (4),
    .MUL_WAIT  (1)
  ) u1 (
    .Clk (clk),
    .Rst (rst),
    .bus (if1)
  );

  logic [10:0] stb0;
  assign stb0 = {if0.in0, if0.selx, if0.ldq,
                 if0.lde, if0.ldt, if0.selq,
                 if0.selrom, if0.selt, if0.selm,
                 if0.sela, if0.sub};

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start/monitor a u0 run until done (bounded).
  task automatic run0(input logic [3:0] nt,
                      input logic a,
                      input bit hold,
                      input bit nostart,
                      output int lat,
                      output int n_acc,
                      output int sbits,
                      output int last,
                      output int n_mul,
                      output int n_go,
                      output int rbad);
    lat = -1; n_acc = 0; sbits = 0;
    last = -1; n_mul = 0; n_go = 0; rbad = 0;
    if (!nostart) begin
      if0.nterms = nt;
      if0.alt    = a;
      if0.Start  = 1'b1;
      tick();
      tick();
    end
    if0.Start = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      tick();
      if (c == 1)
        chk("init_stb", 32'(stb0), 32'h7C0);
      if (hold) begin
        if0.Start  = 1'b1;
        if0.nterms = 4'd5;
        if0.alt    = ~a;
      end
      if (if0.selrom && int'(if0.rom_addr) != n_acc)
        rbad++;
      if (if0.selq || if0.selrom) n_mul++;
      if (if0.mul_go) n_go++;
      if (if0.sela) begin
        sbits = sbits | (int'(if0.sub) << n_acc);
        last  = int'(if0.term_idx);
        n_acc++;
      end
      if (if0.done) begin
        lat = c;
        break;
      end
    end
  endtask

  // u1 run; mul_done rises dly cycles into each MUL stage.
  task automatic run1(input logic [3:0] nt,
                      input int dly,
                      output int lat,
                      output int n_acc,
                      output int n_mul,
                      output int n_go,
                      output int n_ldt,
                      output int lbad);
    int  k;
    logic [1:0] prev;
    logic [1:0] cur;
    lat = -1; n_acc = 0; n_mul = 0;
    n_go = 0; n_ldt = 0; lbad = 0;
    k = 0; prev = 2'b00;
    if1.nterms   = nt;
    if1.alt      = 1'b0;
    if1.mul_done = 1'b1;
    if1.Start    = 1'b1;
    tick();
    tick();
    if1.Start = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      tick();
      cur = {if1.selq, if1.selrom};
      if (cur != 2'b00) begin
        k = (cur != prev) ? 0 : k + 1;
        if1.mul_done = (k == dly);
      end else begin
        if1.mul_done = 1'b1;
      end
      prev = cur;
      #1;
      if (cur != 2'b00) begin
        n_mul++;
        if (if1.mul_go) n_go++;
        if (if1.ldt) n_ldt++;
        if (if1.ldt != if1.mul_done) lbad++;
      end
      if (if1.sela) n_acc++;
      if (if1.done) begin
        lat = c;
        break;
      end
    end
    if1.mul_done = 1'b0;
  endtask

  int lat, nacc, sb, last, nmul, ngo, rb, nldt, lb;
  int ndone;

  initial begin
    if0.Start = 1'b0; if0.nterms = '0;
    if0.alt = 1'b0;   if0.mul_done = 1'b0;
    if1.Start = 1'b0; if1.nterms = '0;
    if1.alt = 1'b0;   if1.mul_done = 1'b0;

    tick();
    tick();
    chk("rst_ready", 32'(if0.ready), 1);
    chk("rst_busy", 32'(if0.busy), 0);
    chk("rst_stb", 32'(stb0), 0);
    chk("rst_done", 32'(if0.done), 0);
    chk("rst_go", 32'(if0.mul_go), 0);
    chk("rst_idx", 32'(if0.term_idx), 0);
    chk("rst_ready1", 32'(if1.ready), 1);
    rst = 1'b0;
    tick();
    chk("idle_ready", 32'(if0.ready), 1);

    // nterms=3, alt=1
    run0(4'd3, 1'b1, 0, 0,
         lat, nacc, sb, last, nmul, ngo, rb);
    chk("n3_lat", lat, 11);
    chk("n3_acc", nacc, 3);
    chk("n3_sub", sb, 2);
    chk("n3_last", last, 2);
    chk("n3_mul", nmul, 6);
    chk("n3_go", ngo, 6);
    chk("n3_rom", rb, 0);
    tick();
    chk("n3_idle", 32'(if0.ready), 1);
    chk("n3_pulse", 32'(if0.done), 0);

    // nterms=0
    run0(4'd0, 1'b0, 0, 0,
         lat, nacc, sb, last, nmul, ngo, rb);
    chk("n0_lat", lat, 2);
    chk("n0_acc", nacc, 0);
    chk("n0_mul", nmul, 0);
    tick();

    // clamp 15 -> 8
    run0(4'd15, 1'b0, 0, 0,
         lat, nacc, sb, last, nmul, ngo, rb);
    chk("n15_acc", nacc, 8);
    chk("n15_last", last, 7);
    chk("n15_lat", lat, 26);
    chk("n15_rom", rb, 0);
    tick();

    // alt=0 / alt=1 with 4 terms
    run0(4'd4, 1'b0, 0, 0,
         lat, nacc, sb, last, nmul, ngo, rb);
    chk("alt0_sub", sb, 0);
    chk("alt0_acc", nacc, 4);
    tick();
    run0(4'd4, 1'b1, 0, 0,
         lat, nacc, sb, last, nmul, ngo, rb);
    chk("alt1_sub", sb, 10);
    tick();

    // Start/nterms/alt changed while busy, Start
    // then held through DONE.
    run0(4'd3, 1'b1, 1, 0,
         lat, nacc, sb, last, nmul, ngo, rb);
    chk("hold_lat", lat, 11);
    chk("hold_acc", nacc, 3);
    chk("hold_sub", sb, 2);
    tick();
    chk("hold_idle", 32'(if0.ready), 1);
    chk("hold_nbusy", 32'(if0.busy), 0);
    tick();
    chk("hold_arm", 32'(if0.busy), 1);
    chk("hold_nrdy", 32'(if0.ready), 0);
    run0(4'd0, 1'b0, 0, 1,
         lat, nacc, sb, last, nmul, ngo, rb);
    chk("re_acc", nacc, 5);
    chk("re_sub", sb, 0);
    tick();

    // reset in MUL_R
    if0.nterms = 4'd3;
    if0.alt    = 1'b1;
    if0.Start  = 1'b1;
    tick();
    if0.Start = 1'b0;
    tick();
    tick();
    tick();
    chk("pre_mulr", 32'(if0.selrom), 1);
    #2 rst = 1'b1;
    #1;
    chk("ab_ready", 32'(if0.ready), 1);
    chk("ab_busy", 32'(if0.busy), 0);
    chk("ab_stb", 32'(stb0), 0);
    chk("ab_idx", 32'(if0.term_idx), 0);
    tick();
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (if0.done) ndone++;
    end
    chk("ab_nodone", ndone, 0);
    chk("ab_idle", 32'(if0.ready), 1);

    // MUL_WAIT=1, 3-cycle multiplier
    run1(4'd2, 3, lat, nacc, nmul, ngo, nldt, lb);
    chk("mw3_go", ngo, 4);
    chk("mw3_mul", nmul, 16);
    chk("mw3_ldt", nldt, 4);
    chk("mw3_lbad", lb, 0);
    chk("mw3_acc", nacc, 2);
    chk("mw3_lat", lat, 20);
    tick();
    chk("mw3_idle", 32'(if1.ready), 1);

    // mul_done together with mul_go
    run1(4'd2, 0, lat, nacc, nmul, ngo, nldt, lb);
    chk("mw0_go", ngo, 4);
    chk("mw0_mul", nmul, 4);
    chk("mw0_lat", lat, 8);
    tick();

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
